mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage consumer of the decoded control bits (reg_write, mem_read, mem_write) from ID.
//   Takes the EX/MEM bundle, runs the data-memory transaction over a req/ack handshake,
//   stalls upstream while it waits, and drives the MEM/WB register.
//   Non-memory ops pass through in one cycle.
// PARAMETERS
//   XLEN        32   data/address width
//   REG_AW      5    destination register index width
//   TIMEOUT     64   max WAIT cycles before bus-error abort (>=2)
// PORTS
//   clk            in   1       single clock, rising edge
//   rst            in   1       asynchronous, active-high reset
//   in_valid       in   1       EX/MEM bundle valid
//   in_reg_write   in   1       control: write rd in WB
//   in_mem_read    in   1       control: load
//   in_mem_write   in   1       control: store
//   in_alu_result  in   XLEN    address (mem op) or result (ALU op)
//   in_store_data  in   XLEN    store data
//   in_rd          in   REG_AW  destination register
//   stall_o        out  1       hold EX/MEM and earlier stages (combinational)
//   dmem_req       out  1       memory request (registered)
//   dmem_we        out  1       1 = write
//   dmem_addr      out  XLEN    word address
//   dmem_wdata     out  XLEN    write data
//   dmem_ack       in   1       request complete; rdata valid same cycle
//   dmem_rdata     in   XLEN    load data
//   wb_valid       out  1       MEM/WB bundle valid
//   wb_reg_write   out  1       write enable to register file
//   wb_rd          out  REG_AW  destination register
//   wb_data        out  XLEN    writeback value
//   err_o          out  1       one-cycle pulse: misaligned, illegal, or timeout
// BEHAVIOUR
//   Reset: all outputs 0 (stall_o follows from state=IDLE, in_* = 0). FSM to IDLE, timer cleared.
//   mem_op = in_valid & (in_mem_read | in_mem_write). ok = mem_op & addr[1:0]==0 & !(rd&wr).
//   IDLE, !mem_op: next edge captures wb_* <= {in_valid, in_reg_write, in_rd, in_alu_result}.
//     Latency 1, stall_o=0.
//   IDLE, ok: stall_o=1. Next edge: dmem_req=1, dmem_we=in_mem_write, addr/wdata latched
//     -> WAIT. wb_valid=0 (bubble).
//   IDLE, mem_op & !ok (misaligned or rd&wr both set): no bus access, stall_o=0.
//     Next edge: wb_valid=1, wb_reg_write=0, err_o=1.
//   WAIT: req/we/addr/wdata held stable. stall_o = !dmem_ack. Timer counts from 0.
//     ack: stall_o=0. Next edge: dmem_req=0 -> IDLE. wb_valid=1, wb_rd=in_rd,
//       wb_reg_write=in_reg_write & in_mem_read, wb_data=load ? dmem_rdata : 0.
//     Zero-wait ack (first WAIT cycle) is legal: total load latency 2 cycles.
//     Timer==TIMEOUT-1 with no ack: drop req -> IDLE. wb_valid=1, wb_reg_write=0, err_o=1.
//       stall_o=0 in that cycle.
//     ack and timeout in the same cycle: ack wins.
//   dmem_ack outside WAIT is ignored. Back-to-back mem ops: a new req issues the cycle after
//     IDLE is re-entered; no req-low gap is guaranteed beyond that cycle.
//   A store never writes a register, even if in_reg_write=1. A load with rd=0 is still
//     issued; the register file drops the write.
//   Reset asserted in WAIT: req drops immediately (async). A late ack after reset is ignored.
//   Timer width = $clog2(TIMEOUT). It saturates and never wraps.
// STRUCTURE
//   pipe_defs.vh (shared include): opcode localparams (LOAD/STORE/RTYPE), FSM state encodings
//     (IDLE=1'b0, WAIT=1'b1), XLEN default.
//   One sub-module, lsu_wait_timer: clear/enable counter with a terminal-count flag.
//     Parameter TIMEOUT.
//   Everything else in one always block for the FSM and one for the MEM/WB register.
// TESTING
//   ALU op: in_reg_write=1, rd=5, alu=0x1234
//     -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, no dmem_req.
//   Load addr 0x100, ack after 3 WAIT cycles, rdata=0xDEADBEEF
//     -> stall_o high for 4 cycles, wb_data=0xDEADBEEF, wb_reg_write=1.
//   Store addr 0x40, data 0xA5A5A5A5, zero-wait ack
//     -> dmem_we=1, addr/wdata match, wb_reg_write=0, stall_o high 1 cycle.
//   Load at addr 0x102 -> no dmem_req, err_o pulse, wb_reg_write=0, no stall.
//   Load, ack never arrives, TIMEOUT=8 -> req drops after 8 WAIT cycles, err_o=1, stall released.
//   rst pulse mid-WAIT, then ack 2 cycles later
//     -> dmem_req=0 immediately, ack ignored, wb_valid stays 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: default widths, FSM states, alignment helper.
package mem_access_unit_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_wait_timer.sv
// Saturating WAIT-cycle counter; tc_o is high while the count sits at TIMEOUT-1.
module mem_access_unit_lsu_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
    tc_d = (count_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs the data-memory req/ack transaction for loads/stores, stalls upstream
// while waiting, and drives the MEM/WB register. Non-memory ops pass through in one cycle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic              mem_op, ok, timer_tc;

  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign ok     = mem_op & word_aligned(in_alu_result[1:0]) & ~(in_mem_read & in_mem_write);

  mem_access_unit_lsu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_IDLE),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (timer_tc)
  );

  // Upstream bundle is held by stall_o during WAIT, so in_* still describe the pending op.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    err_d          = 1'b0;
    stall_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ok) begin
          stall_o = 1'b1;
          req_d   = 1'b1;
          we_d    = in_mem_write;
          addr_d  = in_alu_result;
          wdata_d = in_store_data;
          state_d = ST_WAIT;
        end else if (mem_op) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = in_rd;
          wb_data_d  = '0;
          err_d      = 1'b1;
        end else begin
          wb_valid_d     = in_valid;
          wb_reg_write_d = in_reg_write;
          wb_rd_d        = in_rd;
          wb_data_d      = in_alu_result;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          req_d          = 1'b0;
          state_d        = ST_IDLE;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = in_reg_write & in_mem_read;
          wb_rd_d        = in_rd;
          wb_data_d      = in_mem_read ? dmem_rdata : '0;
        end else if (timer_tc) begin
          req_d      = 1'b0;
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = in_rd;
          wb_data_d  = '0;
          err_d      = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      err_q          <= err_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err_o        = err_q;

endmodule
